filter_stream_selector: RTL and testbench

FILTER_STREAM_SELECTOR -- requirements
Module: filter_stream_selector

---
 rtl/filter_stream_selector.sv | 175 +++++++++++++++++
 tb/tb_filter_stream_selector.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/filter_stream_selector.sv
// Selects one of NUM_CH filter sample streams onto a single framed output.
// Channel switches happen only on frame boundaries. A newly selected channel
// that is mid-frame is drained until its frame ends (ALIGN), so every output
// frame is whole. Non-selected channels are always drained.
module filter_stream_selector #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned FRAME_LEN = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        sel,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic [15:0]              frame_cnt,
  output logic                     len_err
);

  localparam int unsigned ACT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ACT_W-1:0]    r_act;
  logic [ACT_W-1:0]    w_act_nxt;
  logic [NUM_CH-1:0]   r_mid;
  logic [NUM_CH-1:0]   w_mid_nxt;
  logic [NUM_CH-1:0]   w_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_last;
  logic [15:0]         r_frame_cnt;
  logic                r_len_err;

  logic                w_onehot;
  logic [ACT_W-1:0]    w_sel_idx;
  logic                w_sel_mid;
  logic                w_act_acc;
  logic                w_act_last;
  logic [DATA_W-1:0]   w_act_data;
  logic                w_stream_rdy;
  logic                w_beat;
  logic                w_cnt_end;
  state_t              w_eval_state;

  // Handshakes and the mid-frame view every channel will have after this cycle
  assign w_acc        = in_valid & in_ready;
  assign w_mid_nxt    = (w_acc & ~in_last) | (~w_acc & r_mid);
  assign w_stream_rdy = !r_out_valid || out_ready;
  assign w_beat       = (r_state == ST_STREAM) && w_act_acc;
  assign w_cnt_end    = (r_cnt == CNT_LAST);

  // Decode the select vector and mux the active channel's signals
  always_comb begin
    w_onehot   = (sel != '0) && ((sel & (sel - NUM_CH'(1))) == '0);
    w_sel_idx  = '0;
    w_sel_mid  = 1'b0;
    w_act_acc  = 1'b0;
    w_act_last = 1'b0;
    w_act_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel[i]) w_sel_idx = ACT_W'(i);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_sel_idx == ACT_W'(i)) w_sel_mid = w_mid_nxt[i];
      if (r_act == ACT_W'(i)) begin
        w_act_acc  = w_acc[i];
        w_act_last = in_last[i];
        w_act_data = in_data[i*DATA_W +: DATA_W];
      end
    end
    // Mid-frame is judged after this cycle's drain so a frame start is never skipped
    if (!w_onehot)      w_eval_state = ST_IDLE;
    else if (w_sel_mid) w_eval_state = ST_ALIGN;
    else                w_eval_state = ST_STREAM;
  end

  // State and active-channel register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_act   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_act   <= w_act_nxt;
    end
  end

  // Next state: sel is honoured only outside STREAM or at the active frame's end
  always_comb begin
    w_state_nxt = r_state;
    w_act_nxt   = r_act;
    case (r_state)
      ST_IDLE, ST_ALIGN: begin
        w_state_nxt = w_eval_state;
        if (w_onehot) w_act_nxt = w_sel_idx;
      end
      ST_STREAM: begin
        if (w_act_acc && w_act_last) begin
          w_state_nxt = w_eval_state;
          if (w_onehot) w_act_nxt = w_sel_idx;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Ready outputs: everything drains except the active channel while streaming
  always_comb begin
    in_ready = '0;
    if (rst_n) begin
      in_ready = '1;
      if (r_state == ST_STREAM) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (r_act == ACT_W'(i)) in_ready[i] = w_stream_rdy;
        end
      end
    end
  end

  // Output stage, frame counter, beat counter and length checker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mid       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_frame_cnt <= '0;
      r_len_err   <= 1'b0;
    end else begin
      r_mid     <= w_mid_nxt;
      r_len_err <= 1'b0;
      if (w_beat) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_act_data;
        r_out_last  <= w_act_last;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (r_out_valid && out_ready && r_out_last) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (w_beat) begin
        if (w_act_last || w_cnt_end) begin
          r_cnt     <= '0;
          r_len_err <= (w_act_last != w_cnt_end);
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign frame_cnt = r_frame_cnt;
  assign len_err   = r_len_err;

endmodule

// File: tb/tb_filter_stream_selector.sv
// Directed bench for filter_stream_selector with NUM_CH=2, FRAME_LEN=4.
module tb_filter_stream_selector;

  localparam int unsigned DW = 8;
  localparam int unsigned NC = 2;
  localparam int unsigned FL = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NC-1:0] sel;
  logic [DW-1:0] d0, d1;
  logic [NC-1:0] in_valid, in_last, in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid, out_last, out_ready;
  logic [15:0]   frame_cnt;
  logic          len_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  filter_stream_selector #(.DATA_W(DW), .NUM_CH(NC), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .in_data({d1, d0}),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .frame_cnt(frame_cnt), .len_err(len_err)
  );

  typedef struct {
    logic [1:0] vld;
    logic [1:0] lst;
    int         d0;
    int         ordy;
    logic [1:0] eir;
    int         eov;
    int         eod;
    int         eol;
    int         efc;
    int         eerr;
  } vec_t;

  vec_t tbl [28];

  function automatic vec_t mk(input int v, input int l, input int d, input int r,
                              input logic [1:0] eir, input int eov, input int eod,
                              input int eol, input int efc, input int eerr);
    vec_t t;
    t.vld  = {1'b0, 1'(v)};
    t.lst  = {1'b0, 1'(l)};
    t.d0   = d;
    t.ordy = r;
    t.eir  = eir;
    t.eov  = eov;
    t.eod  = eod;
    t.eol  = eol;
    t.efc  = efc;
    t.eerr = eerr;
    return t;
  endfunction

  task automatic drive(input logic [1:0] s, input logic [1:0] v, input logic [1:0] l,
                       input int a, input int b, input int r);
    sel       = s;
    in_valid  = v;
    in_last   = l;
    d0        = 8'(a);
    d1        = 8'(b);
    out_ready = 1'(r);
  endtask

  // Data/last are compared whenever valid is expected, or when forced (reset)
  task automatic check(input string nm, input logic [1:0] eir, input int eov, input int eod,
                       input int eol, input int efc, input int eerr, input int chkd);
    logic bad;
    checks++;
    bad = (in_ready !== eir) || (out_valid !== 1'(eov)) ||
          (frame_cnt !== 16'(efc)) || (len_err !== 1'(eerr));
    if (chkd != 0 || eov != 0)
      bad = bad || (out_data !== 8'(eod)) || (out_last !== 1'(eol));
    if (bad) begin
      failures++;
      $display("FAIL %s: got ir=%b ov=%b od=%0d ol=%b fc=%0d err=%b, want ir=%b ov=%0d od=%0d ol=%0d fc=%0d err=%0d",
               nm, in_ready, out_valid, out_data, out_last, frame_cnt, len_err,
               eir, eov, eod, eol, efc, eerr);
    end
  endtask

  // One cycle: drive after the falling edge, check before the next rising edge
  task automatic cyc(input string nm, input logic [1:0] s, input logic [1:0] v,
                     input logic [1:0] l, input int a, input int b, input int r,
                     input logic [1:0] eir, input int eov, input int eod,
                     input int eol, input int efc, input int eerr);
    @(negedge clk);
    drive(s, v, l, a, b, r);
    #2;
    check(nm, eir, eov, eod, eol, efc, eerr, 0);
  endtask

  initial begin
    // Frame on ch0, backpressure toggling, short frame, long frame
    tbl[0]  = mk(1, 0,  1, 1, 2'b11, 0,  0, 0, 0, 0);
    tbl[1]  = mk(1, 0,  2, 1, 2'b11, 1,  1, 0, 0, 0);
    tbl[2]  = mk(1, 0,  3, 1, 2'b11, 1,  2, 0, 0, 0);
    tbl[3]  = mk(1, 1,  4, 1, 2'b11, 1,  3, 0, 0, 0);
    tbl[4]  = mk(0, 0,  0, 1, 2'b11, 1,  4, 1, 0, 0);
    tbl[5]  = mk(0, 0,  0, 1, 2'b11, 0,  0, 0, 1, 0);
    tbl[6]  = mk(1, 0, 10, 1, 2'b11, 0,  0, 0, 1, 0);
    tbl[7]  = mk(1, 0, 11, 0, 2'b10, 1, 10, 0, 1, 0);
    tbl[8]  = mk(1, 0, 11, 1, 2'b11, 1, 10, 0, 1, 0);
    tbl[9]  = mk(1, 0, 12, 0, 2'b10, 1, 11, 0, 1, 0);
    tbl[10] = mk(1, 0, 12, 1, 2'b11, 1, 11, 0, 1, 0);
    tbl[11] = mk(1, 1, 13, 0, 2'b10, 1, 12, 0, 1, 0);
    tbl[12] = mk(1, 1, 13, 1, 2'b11, 1, 12, 0, 1, 0);
    tbl[13] = mk(0, 0,  0, 0, 2'b10, 1, 13, 1, 1, 0);
    tbl[14] = mk(0, 0,  0, 1, 2'b11, 1, 13, 1, 1, 0);
    tbl[15] = mk(0, 0,  0, 1, 2'b11, 0,  0, 0, 2, 0);
    tbl[16] = mk(1, 0, 20, 1, 2'b11, 0,  0, 0, 2, 0);
    tbl[17] = mk(1, 0, 21, 1, 2'b11, 1, 20, 0, 2, 0);
    tbl[18] = mk(1, 1, 22, 1, 2'b11, 1, 21, 0, 2, 0);
    tbl[19] = mk(0, 0,  0, 1, 2'b11, 1, 22, 1, 2, 1);
    tbl[20] = mk(0, 0,  0, 1, 2'b11, 0,  0, 0, 3, 0);
    tbl[21] = mk(1, 0, 30, 1, 2'b11, 0,  0, 0, 3, 0);
    tbl[22] = mk(1, 0, 31, 1, 2'b11, 1, 30, 0, 3, 0);
    tbl[23] = mk(1, 0, 32, 1, 2'b11, 1, 31, 0, 3, 0);
    tbl[24] = mk(1, 0, 33, 1, 2'b11, 1, 32, 0, 3, 0);
    tbl[25] = mk(1, 1, 34, 1, 2'b11, 1, 33, 0, 3, 1);
    tbl[26] = mk(0, 0,  0, 1, 2'b11, 1, 34, 1, 3, 1);
    tbl[27] = mk(0, 0,  0, 1, 2'b11, 0,  0, 0, 4, 0);

    rst_n = 1'b0;
    drive(2'b01, 2'b00, 2'b00, 0, 0, 1);
    @(negedge clk);
    #2;
    check("reset", 2'b00, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("release_idle", 2'b11, 0, 0, 0, 0, 0, 1);

    for (int k = 0; k < 28; k++) begin
      cyc($sformatf("vec%0d", k), 2'b01, tbl[k].vld, tbl[k].lst, tbl[k].d0, 0, tbl[k].ordy,
          tbl[k].eir, tbl[k].eov, tbl[k].eod, tbl[k].eol, tbl[k].efc, tbl[k].eerr);
    end

    // Switch 01->10 mid-frame; ch1 is mid-frame so it aligns first
    cyc("A0",  2'b01, 2'b01, 2'b00, 40,   0, 1, 2'b11, 0,   0, 0, 4, 0);
    cyc("A1",  2'b01, 2'b11, 2'b00, 41,  90, 1, 2'b11, 1,  40, 0, 4, 0);
    cyc("A2",  2'b10, 2'b11, 2'b00, 42,  91, 1, 2'b11, 1,  41, 0, 4, 0);
    cyc("A3",  2'b10, 2'b11, 2'b01, 43,  92, 1, 2'b11, 1,  42, 0, 4, 0);
    cyc("A4",  2'b10, 2'b10, 2'b10,  0,  93, 1, 2'b11, 1,  43, 1, 4, 0);
    cyc("A5",  2'b10, 2'b10, 2'b00,  0, 100, 1, 2'b11, 0,   0, 0, 5, 0);
    cyc("A6",  2'b10, 2'b10, 2'b00,  0, 101, 1, 2'b11, 1, 100, 0, 5, 0);
    cyc("A7",  2'b10, 2'b10, 2'b00,  0, 102, 1, 2'b11, 1, 101, 0, 5, 0);
    cyc("A8",  2'b10, 2'b10, 2'b10,  0, 103, 1, 2'b11, 1, 102, 0, 5, 0);
    cyc("A9",  2'b10, 2'b00, 2'b00,  0,   0, 1, 2'b11, 1, 103, 1, 5, 0);
    cyc("A10", 2'b10, 2'b00, 2'b00,  0,   0, 1, 2'b11, 0,   0, 0, 6, 0);

    // Multi-bit sel mid-frame: frame finishes, then idle with everything drained
    cyc("B0", 2'b10, 2'b10, 2'b00, 0, 110, 1, 2'b11, 0,   0, 0, 6, 0);
    cyc("B1", 2'b11, 2'b10, 2'b00, 0, 111, 1, 2'b11, 1, 110, 0, 6, 0);
    cyc("B2", 2'b11, 2'b10, 2'b00, 0, 112, 1, 2'b11, 1, 111, 0, 6, 0);
    cyc("B3", 2'b11, 2'b10, 2'b10, 0, 113, 1, 2'b11, 1, 112, 0, 6, 0);
    cyc("B4", 2'b11, 2'b11, 2'b11, 7,   8, 1, 2'b11, 1, 113, 1, 6, 0);
    cyc("B5", 2'b11, 2'b11, 2'b11, 7,   8, 1, 2'b11, 0,   0, 0, 7, 0);
    cyc("B6", 2'b11, 2'b00, 2'b00, 0,   0, 1, 2'b11, 0,   0, 0, 7, 0);

    // Reset mid-frame with an output beat pending, then a fresh frame
    cyc("C0", 2'b01, 2'b00, 2'b00,  0, 0, 1, 2'b11, 0,  0, 0, 7, 0);
    cyc("C1", 2'b01, 2'b01, 2'b00, 50, 0, 1, 2'b11, 0,  0, 0, 7, 0);
    cyc("C2", 2'b01, 2'b01, 2'b00, 51, 0, 0, 2'b10, 1, 50, 0, 7, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("C_rst_async", 2'b00, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    #2;
    check("C_rst_hold", 2'b00, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b01, 2'b00, 2'b00, 0, 0, 1);
    #2;
    check("C_release", 2'b11, 0, 0, 0, 0, 0, 1);
    cyc("R1", 2'b01, 2'b01, 2'b00, 60, 0, 1, 2'b11, 0,  0, 0, 0, 0);
    cyc("R2", 2'b01, 2'b01, 2'b00, 61, 0, 1, 2'b11, 1, 60, 0, 0, 0);
    cyc("R3", 2'b01, 2'b01, 2'b00, 62, 0, 1, 2'b11, 1, 61, 0, 0, 0);
    cyc("R4", 2'b01, 2'b01, 2'b01, 63, 0, 1, 2'b11, 1, 62, 0, 0, 0);
    cyc("R5", 2'b01, 2'b00, 2'b00,  0, 0, 1, 2'b11, 1, 63, 1, 0, 0);
    cyc("R6", 2'b01, 2'b00, 2'b00,  0, 0, 1, 2'b11, 0,  0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
